// File: rtl/writeback_unit_if.sv
// MEM3 -> WB hand-off plus the register-file write port driven back to decode.
// The master drives MEM3 and the data cache; the slave is the writeback unit.
interface writeback_unit_if;
  logic        valid_mem3;
  logic [1:0]  type_mem3;
  logic [4:0]  rd_mem3;
  logic [31:0] alu_res_mem3;
  logic [31:0] pc4_mem3;
  logic [2:0]  funct3_mem3;
  logic [1:0]  addr_lsb_mem3;
  logic [31:0] load_data;
  logic        data_cache_ready;
  logic        mem3_ready;
  logic [1:0]  type_mem3_wb;
  logic [4:0]  wb_des;
  logic [31:0] wb_data;

  // Handshake: an instruction is taken in a cycle where valid_mem3 & mem3_ready
  // and type_mem3 != 00. mem3_ready depends on WB state only, never on valid_mem3.
  // The write port is a one-cycle pulse: type_mem3_wb != 00 marks a valid write.
  modport master (
    output valid_mem3, type_mem3, rd_mem3, alu_res_mem3, pc4_mem3,
           funct3_mem3, addr_lsb_mem3, load_data, data_cache_ready,
    input  mem3_ready, type_mem3_wb, wb_des, wb_data
  );

  modport slave (
    input  valid_mem3, type_mem3, rd_mem3, alu_res_mem3, pc4_mem3,
           funct3_mem3, addr_lsb_mem3, load_data, data_cache_ready,
    output mem3_ready, type_mem3_wb, wb_des, wb_data
  );
endinterface

// File: rtl/writeback_unit.sv
// Final pipeline stage: picks ALU result, formatted load data or link address,
// drives the register-file write pulse, stalls MEM3 on a cache miss, counts retires.
module writeback_unit #(
  parameter int CNT_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  writeback_unit_if.slave   mem3,
  output logic [CNT_W-1:0]  o_retire_count,
  output logic              o_dbg_load_wait
);

  typedef enum logic {
    S_IDLE      = 1'b0,
    S_LOAD_WAIT = 1'b1
  } state_t;

  localparam logic [1:0] T_IDLE = 2'b00;
  localparam logic [1:0] T_ALU  = 2'b01;
  localparam logic [1:0] T_LOAD = 2'b10;
  localparam logic [1:0] T_JAL  = 2'b11;

  state_t             r_state;
  state_t             w_next_state;
  logic [4:0]         r_pend_rd;
  logic [2:0]         r_pend_funct3;
  logic [1:0]         r_pend_lsb;
  logic [1:0]         r_wb_type;
  logic [4:0]         r_wb_des;
  logic [31:0]        r_wb_data;
  logic [CNT_W-1:0]   r_retire_count;

  logic               w_accept;
  logic               w_issue;
  logic               w_latch;
  logic [1:0]         w_issue_type;
  logic [4:0]         w_issue_rd;
  logic [31:0]        w_issue_data;

  function automatic logic [31:0] f_format(input logic [31:0] d, input logic [2:0] f3,
                                           input logic [1:0] lsb);
    logic [7:0]  b;
    logic [15:0] h;
    b = d[{lsb, 3'b000} +: 8];
    h = d[{lsb[1], 4'b0000} +: 16];
    case (f3)
      3'b000:  f_format = {{24{b[7]}}, b};
      3'b001:  f_format = {{16{h[15]}}, h};
      3'b100:  f_format = {24'b0, b};
      3'b101:  f_format = {16'b0, h};
      default: f_format = d;
    endcase
  endfunction

  assign w_accept = mem3.valid_mem3 && (r_state == S_IDLE) && (mem3.type_mem3 != T_IDLE);

  always_comb begin
    w_next_state = r_state;
    w_issue      = 1'b0;
    w_latch      = 1'b0;
    w_issue_type = T_IDLE;
    w_issue_rd   = mem3.rd_mem3;
    w_issue_data = mem3.alu_res_mem3;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          case (mem3.type_mem3)
            T_ALU: begin
              w_issue      = 1'b1;
              w_issue_type = T_ALU;
            end
            T_JAL: begin
              w_issue      = 1'b1;
              w_issue_type = T_JAL;
              w_issue_data = mem3.pc4_mem3;
            end
            default: begin
              if (mem3.data_cache_ready) begin
                w_issue      = 1'b1;
                w_issue_type = T_LOAD;
                w_issue_data = f_format(mem3.load_data, mem3.funct3_mem3, mem3.addr_lsb_mem3);
              end else begin
                w_latch      = 1'b1;
                w_next_state = S_LOAD_WAIT;
              end
            end
          endcase
        end
      end
      S_LOAD_WAIT: begin
        // MEM3 inputs are ignored here; only the cache return matters.
        if (mem3.data_cache_ready) begin
          w_issue      = 1'b1;
          w_issue_type = T_LOAD;
          w_issue_rd   = r_pend_rd;
          w_issue_data = f_format(mem3.load_data, r_pend_funct3, r_pend_lsb);
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pend_rd     <= 5'd0;
      r_pend_funct3 <= 3'd0;
      r_pend_lsb    <= 2'd0;
    end else if (w_latch) begin
      r_pend_rd     <= mem3.rd_mem3;
      r_pend_funct3 <= mem3.funct3_mem3;
      r_pend_lsb    <= mem3.addr_lsb_mem3;
    end
  end

  // A write to x0 still retires but leaves the write port idle and unchanged.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wb_type      <= T_IDLE;
      r_wb_des       <= 5'd0;
      r_wb_data      <= 32'd0;
      r_retire_count <= '0;
    end else begin
      r_wb_type <= T_IDLE;
      if (w_issue) begin
        r_retire_count <= r_retire_count + {{(CNT_W-1){1'b0}}, 1'b1};
        if (w_issue_rd != 5'd0) begin
          r_wb_type <= w_issue_type;
          r_wb_des  <= w_issue_rd;
          r_wb_data <= w_issue_data;
        end
      end
    end
  end

  assign mem3.mem3_ready   = (r_state == S_IDLE);
  assign mem3.type_mem3_wb = r_wb_type;
  assign mem3.wb_des       = r_wb_des;
  assign mem3.wb_data      = r_wb_data;
  assign o_retire_count    = r_retire_count;
  assign o_dbg_load_wait   = (r_state == S_LOAD_WAIT);

endmodule

// File: tb/tb_writeback_unit.sv
// Bench for writeback_unit: directed corner cases then random traffic, each cycle
// checked against an instruction-level model of what should retire and be written.
module tb_writeback_unit;
  localparam int CNT_W = 4;

  logic             clk;
  logic             rst_n;
  logic [CNT_W-1:0] retire_count;
  logic             dbg_load_wait;
  int               n_cmp;
  int               n_err;

  writeback_unit_if bus ();

  writeback_unit #(.CNT_W(CNT_W)) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .mem3            (bus.slave),
    .o_retire_count  (retire_count),
    .o_dbg_load_wait (dbg_load_wait)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: what the write port and counter must show after each edge
  logic        m_pending;
  logic [4:0]  m_rd;
  logic [2:0]  m_f3;
  logic [1:0]  m_off;
  int unsigned m_cnt;
  logic [1:0]  m_type;
  logic [4:0]  m_des;
  logic [31:0] m_data;

  function automatic logic [31:0] fmt(input logic [31:0] w, input logic [2:0] f3,
                                      input logic [1:0] off);
    int unsigned b;
    int unsigned h;
    b = (w >> (8 * off)) % 256;
    h = (w >> (16 * (off / 2))) % 65536;
    case (f3)
      3'd0:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      3'd1:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pending = 1'b0;
    m_rd = 5'd0; m_f3 = 3'd0; m_off = 2'd0;
    m_cnt = 0; m_type = 2'b00; m_des = 5'd0; m_data = 32'd0;
  endtask

  // driver
  task automatic drive(input logic v, input logic [1:0] t, input logic [4:0] rd,
                       input logic [31:0] alu, input logic [31:0] pc4, input logic [2:0] f3,
                       input logic [1:0] off, input logic [31:0] ld, input logic dcr);
    bus.valid_mem3       = v;
    bus.type_mem3        = t;
    bus.rd_mem3          = rd;
    bus.alu_res_mem3     = alu;
    bus.pc4_mem3         = pc4;
    bus.funct3_mem3      = f3;
    bus.addr_lsb_mem3    = off;
    bus.load_data        = ld;
    bus.data_cache_ready = dcr;
  endtask

  // one clock with the currently driven inputs; checks ready before and outputs after
  task automatic step(input string tag);
    logic        retire;
    logic [1:0]  wt;
    logic [4:0]  wrd;
    logic [31:0] wd;
    check({tag, ".ready"}, {31'd0, bus.mem3_ready}, {31'd0, !m_pending});
    retire = 1'b0; wt = 2'b00; wrd = 5'd0; wd = 32'd0;
    if (m_pending) begin
      if (bus.data_cache_ready) begin
        retire = 1'b1; wt = 2'b10; wrd = m_rd;
        wd = fmt(bus.load_data, m_f3, m_off);
        m_pending = 1'b0;
      end
    end else if (bus.valid_mem3 && bus.type_mem3 != 2'b00) begin
      wrd = bus.rd_mem3;
      if (bus.type_mem3 == 2'b01) begin
        retire = 1'b1; wt = 2'b01; wd = bus.alu_res_mem3;
      end else if (bus.type_mem3 == 2'b11) begin
        retire = 1'b1; wt = 2'b11; wd = bus.pc4_mem3;
      end else if (bus.data_cache_ready) begin
        retire = 1'b1; wt = 2'b10; wd = fmt(bus.load_data, bus.funct3_mem3, bus.addr_lsb_mem3);
      end else begin
        m_pending = 1'b1; m_rd = bus.rd_mem3; m_f3 = bus.funct3_mem3; m_off = bus.addr_lsb_mem3;
      end
    end
    m_type = 2'b00;
    if (retire) begin
      m_cnt = (m_cnt + 1) % (1 << CNT_W);
      if (wrd != 5'd0) begin
        m_type = wt; m_des = wrd; m_data = wd;
      end
    end
    @(posedge clk);
    #1;
    check({tag, ".type"}, {30'd0, bus.type_mem3_wb}, {30'd0, m_type});
    check({tag, ".des"},  {27'd0, bus.wb_des}, {27'd0, m_des});
    check({tag, ".data"}, bus.wb_data, m_data);
    check({tag, ".cnt"},  32'(retire_count), m_cnt);
    check({tag, ".busy"}, {31'd0, dbg_load_wait}, {31'd0, m_pending});
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, ".type"},  {30'd0, bus.type_mem3_wb}, 32'd0);
    check({tag, ".des"},   {27'd0, bus.wb_des}, 32'd0);
    check({tag, ".data"},  bus.wb_data, 32'd0);
    check({tag, ".cnt"},   32'(retire_count), 32'd0);
    check({tag, ".ready"}, {31'd0, bus.mem3_ready}, 32'd1);
  endtask

  localparam logic [31:0] LD = 32'h80FF_7F01;

  initial begin
    n_cmp = 0;
    n_err = 0;
    model_reset();
    drive(1'b0, 2'b00, 5'd0, 32'd0, 32'd0, 3'd0, 2'd0, 32'd0, 1'b0);
    rst_n = 1'b0;
    #3;
    check_reset_values("reset0");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // ALU write, then pulse drops
    drive(1'b1, 2'b01, 5'd5, 32'h1234_5678, 32'd0, 3'd0, 2'd0, 32'd0, 1'b1);
    step("alu");
    drive(1'b0, 2'b01, 5'd6, 32'hDEAD_BEEF, 32'd0, 3'd0, 2'd0, 32'd0, 1'b1);
    step("alu_drop");

    // load format with cache hit
    drive(1'b1, 2'b10, 5'd7, 32'd0, 32'd0, 3'd0, 2'd3, LD, 1'b1); step("lb3");
    check("lb3.val", bus.wb_data, 32'hFFFF_FF80);
    drive(1'b1, 2'b10, 5'd8, 32'd0, 32'd0, 3'd4, 2'd3, LD, 1'b1); step("lbu3");
    check("lbu3.val", bus.wb_data, 32'h0000_0080);
    drive(1'b1, 2'b10, 5'd9, 32'd0, 32'd0, 3'd1, 2'd2, LD, 1'b1); step("lh2");
    check("lh2.val", bus.wb_data, 32'hFFFF_80FF);
    drive(1'b1, 2'b10, 5'd10, 32'd0, 32'd0, 3'd5, 2'd0, LD, 1'b1); step("lhu0");
    check("lhu0.val", bus.wb_data, 32'h0000_7F01);
    drive(1'b1, 2'b10, 5'd11, 32'd0, 32'd0, 3'd2, 2'd1, LD, 1'b1); step("lw");
    check("lw.val", bus.wb_data, LD);
    drive(1'b1, 2'b10, 5'd12, 32'd0, 32'd0, 3'd7, 2'd2, LD, 1'b1); step("lundef");

    // load miss: three stalled cycles with garbage on MEM3, then the hit
    drive(1'b1, 2'b10, 5'd13, 32'd0, 32'd0, 3'd0, 2'd1, LD, 1'b0); step("miss_acc");
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 2'b01, 5'd14, 32'hAAAA_0000 + i, 32'd0, 3'd2, 2'd0, 32'h1111_2222, 1'b0);
      step("miss_wait");
    end
    drive(1'b1, 2'b01, 5'd15, 32'hBBBB_0000, 32'd0, 3'd2, 2'd0, LD, 1'b1); step("miss_hit");
    check("miss_hit.val", bus.wb_data, 32'h0000_007F);
    drive(1'b0, 2'b00, 5'd0, 32'd0, 32'd0, 3'd0, 2'd0, 32'd0, 1'b0); step("miss_after");

    // jump-link to x0 retires without a write; then to a real register
    drive(1'b1, 2'b11, 5'd0, 32'd0, 32'h0000_0104, 3'd0, 2'd0, 32'd0, 1'b0); step("jal_x0");
    drive(1'b1, 2'b11, 5'd1, 32'd0, 32'h0000_0208, 3'd0, 2'd0, 32'd0, 1'b0); step("jal_x1");

    // 16 back-to-back ALU retires: counter passes through its wrap point
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 2'b01, 5'($urandom_range(1, 31)), $urandom, 32'd0, 3'd0, 2'd0, 32'd0, 1'b0);
      step("wrap");
    end

    // random traffic
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)),
            $urandom, $urandom, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
            $urandom, $urandom_range(0, 2) != 0);
      step("rand");
    end

    // reset while a load is pending: outputs clear without a clock edge
    drive(1'b1, 2'b01, 5'd3, 32'h5555_AAAA, 32'd0, 3'd0, 2'd0, 32'd0, 1'b1); step("pre_rst");
    drive(1'b1, 2'b10, 5'd4, 32'd0, 32'd0, 3'd2, 2'd0, LD, 1'b0); step("pre_rst_miss");
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("reset_mid");
    check("reset_mid.busy", {31'd0, dbg_load_wait}, 32'd0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive(1'b0, 2'b00, 5'd0, 32'd0, 32'd0, 3'd0, 2'd0, LD, 1'b1); step("post_rst");
    drive(1'b1, 2'b01, 5'd2, 32'hCAFE_F00D, 32'd0, 3'd0, 2'd0, 32'd0, 1'b0); step("post_rst_alu");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
